// File: rtl/blink_tick_gen_pkg.sv
// blink_pkg: shared types and constants for the LED blink pacing block.
// Build option: define BLINK_SIM_FAST_EN to force BASE_DIV=64 and
// DEBOUNCE_CYC=4 regardless of the parameters passed in.
package blink_pkg;

    // Rate index: 0 = slowest (BASE_DIV), 3 = fastest (BASE_DIV/8)
    typedef logic [1:0] rate_t;

    localparam int NUM_RATES        = 4;
    localparam int BASE_DIV_DEF     = 50_000_000;
    localparam int DEBOUNCE_CYC_DEF = 500_000;

`ifdef BLINK_SIM_FAST_EN
    localparam bit SIM_FAST = 1'b1;
`else
    localparam bit SIM_FAST = 1'b0;
`endif

    localparam int FAST_BASE_DIV     = 64;
    localparam int FAST_DEBOUNCE_CYC = 4;

    // Debounce FSM states
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } db_state_e;

    // Divider length actually built, after the fast-build override
    function automatic int eff_base_div(input int base_div);
        return SIM_FAST ? FAST_BASE_DIV : base_div;
    endfunction

    // Debounce length actually built, after the fast-build override
    function automatic int eff_debounce_cyc(input int debounce_cyc);
        return SIM_FAST ? FAST_DEBOUNCE_CYC : debounce_cyc;
    endfunction

endpackage

// File: rtl/blink_tick_gen_if.sv
// blink_tick_gen_if: raw pushbuttons in, pacing outputs to the LED FSM.
// master = the tick generator, slave = the board/LED side.
interface blink_tick_gen_if;
    import blink_pkg::*;

    logic  key_rate_n;   // raw, active-low, asynchronous to clk
    logic  key_pause_n;  // raw, active-low, asynchronous to clk
    logic  tick;         // one-cycle enable for the LED FSM
    rate_t rate_sel;     // current rate index
    logic  paused;       // 1 = ticking suspended

    modport master (
        input  key_rate_n,
        input  key_pause_n,
        output tick,
        output rate_sel,
        output paused
    );

    modport slave (
        output key_rate_n,
        output key_pause_n,
        input  tick,
        input  rate_sel,
        input  paused
    );

endinterface

// File: rtl/blink_tick_gen_key_debounce.sv
// key_debounce: 2-flop synchroniser followed by a press/release debounce
// FSM. Emits exactly one single-cycle press_o per accepted physical press;
// a held key produces no repeats, and a release must also be stable for
// DEBOUNCE_CYC cycles before another press can be recognised.
module key_debounce
    import blink_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic press_o
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync_q;
    logic             synced;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Synchroniser; resets to the released level so reset never looks like a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_n_i};
        end
    end

    assign synced = sync_q[1];

    // FSM state and stability counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; press_o fires in the cycle the low level has been stable long enough
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (!synced) begin
                    cnt_d   = '0;
                    state_d = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (synced) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    press_o = 1'b1;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (synced) begin
                    cnt_d   = '0;
                    state_d = REL_WAIT;
                end
            end
            REL_WAIT: begin
                if (!synced) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/blink_tick_gen.sv
// blink_tick_gen: produces a registered one-cycle clock-enable 'tick' for
// the LED blink FSM. Period is BASE_DIV >> rate_sel clk cycles. A debounced
// rate key steps rate_sel 0..3 (wrapping) and restarts the period; a
// debounced pause key freezes the divider without losing its position.
// Build option: BLINK_SIM_FAST_EN overrides BASE_DIV=64, DEBOUNCE_CYC=4.
// BASE_DIV must be a multiple of 8 (so every rate divides evenly) and >= 8;
// DEBOUNCE_CYC must be >= 2.
module blink_tick_gen
    import blink_pkg::*;
#(
    parameter int BASE_DIV     = BASE_DIV_DEF,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    blink_tick_gen_if.master  bus
);

    localparam int BD_EFF = eff_base_div(BASE_DIV);
    localparam int DC_EFF = eff_debounce_cyc(DEBOUNCE_CYC);
    localparam int CNT_W  = $clog2(BD_EFF);

    logic             rate_press;
    logic             pause_press;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_last;
    rate_t            rate_q, rate_d;
    logic             paused_q, paused_d;
    logic             tick_q, tick_d;

    key_debounce #(.DEBOUNCE_CYC(DC_EFF)) u_db_rate (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n_i (bus.key_rate_n),
        .press_o (rate_press)
    );

    key_debounce #(.DEBOUNCE_CYC(DC_EFF)) u_db_pause (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n_i (bus.key_pause_n),
        .press_o (pause_press)
    );

    // Terminal count for the selected rate: (BASE_DIV >> rate) - 1
    assign period_last = CNT_W'((BD_EFF >> rate_q) - 1);

    // Divider, rate and pause registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            rate_q   <= '0;
            paused_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rate_q   <= rate_d;
            paused_q <= paused_d;
            tick_q   <= tick_d;
        end
    end

    // A rate press wins over a terminal count (no tick, restart from 0) and
    // applies even while paused. Pause uses the pre-press paused state, so a
    // pause landing on the terminal count still lets that tick through.
    always_comb begin
        cnt_d    = cnt_q;
        rate_d   = rate_q;
        tick_d   = 1'b0;
        paused_d = paused_q ^ pause_press;
        if (rate_press) begin
            rate_d = (rate_q == rate_t'(NUM_RATES - 1)) ? '0 : rate_q + 1'b1;
            cnt_d  = '0;
        end else if (!paused_q) begin
            if (cnt_q == period_last) begin
                tick_d = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign bus.tick     = tick_q;
    assign bus.rate_sel = rate_q;
    assign bus.paused   = paused_q;

endmodule
